// File: rtl/kmap_sweep_checker.sv
// kmap_sweep_checker: sweeps a 4-input combinational block through all 16
// codes, samples its output f, and compares each sample against a latched
// expected mask. Codes whose care bit is 0 are skipped. Results are the
// pass flag, the mismatch count and the lowest failing code.
module kmap_sweep_checker #(
  parameter int unsigned SETTLE = 0
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        start,
  input  logic [15:0] expect_mask,
  input  logic [15:0] care_mask,
  input  logic        f,
  output logic [3:0]  x,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail,
  output logic        first_fail_valid
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [3:0]  hold;
  logic [15:0] exp_q;
  logic [15:0] care_q;

  logic        sample;
  logic        miss;
  logic [4:0]  cnt_nxt;

  // Sample f on the last hold cycle of the current code. The 4-state
  // compare makes an X/Z at a cared code count as a mismatch in simulation;
  // hardware sees an ordinary inequality.
  always_comb begin
    sample  = (state == HOLD) && (hold == SETTLE_C);
    miss    = sample && care_q[idx] && (f !== exp_q[idx]);
    cnt_nxt = mismatch_cnt + 5'(miss);
  end

  // Next-state and the state-decoded outputs.
  always_comb begin
    state_nxt = state;
    x         = 4'd0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = HOLD;
      HOLD: begin
        x    = idx;
        busy = 1'b1;
        if (sample && idx == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sweep index, hold counter, latched masks and result registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      idx              <= 4'd0;
      hold             <= 4'd0;
      exp_q            <= 16'd0;
      care_q           <= 16'd0;
      pass             <= 1'b0;
      mismatch_cnt     <= 5'd0;
      first_fail       <= 4'd0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          exp_q            <= expect_mask;
          care_q           <= care_mask;
          idx              <= 4'd0;
          hold             <= 4'd0;
          pass             <= 1'b0;
          mismatch_cnt     <= 5'd0;
          first_fail       <= 4'd0;
          first_fail_valid <= 1'b0;
        end
        HOLD: begin
          if (sample) begin
            mismatch_cnt <= cnt_nxt;
            if (miss && !first_fail_valid) begin
              first_fail       <= idx;
              first_fail_valid <= 1'b1;
            end
            hold <= 4'd0;
            if (idx == 4'd15) pass <= (cnt_nxt == 5'd0);
            else              idx  <= idx + 4'd1;
          end else begin
            hold <= hold + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
